// File: rtl/rssb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rssb_pkg                                                             |
// | Shared types and constants for the rssb trace stage.                 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package rssb_pkg;

    localparam int REC_WORDS   = 5;
    localparam int TRACE_WIDTH = 8;

    typedef logic [2:0] rec_idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } trace_state_t;

    // Word 0 holds opc, word 4 holds oacc.
    typedef logic [REC_WORDS-1:0][TRACE_WIDTH-1:0] trace_rec_t;

    localparam rec_idx_t LAST_IDX = rec_idx_t'(REC_WORDS - 1);

endpackage
`default_nettype wire

// File: rtl/rssb_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rssb_trace_fifo                                                      |
// | Circular record buffer with push/pop and registered occupancy.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rssb_trace_fifo
    import rssb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [REC_WORDS-1:0][WIDTH-1:0] wdata,
    output logic [REC_WORDS-1:0][WIDTH-1:0] rdata,
    output logic                            full,
    output logic                            empty
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

    logic [REC_WORDS-1:0][WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]                 r_wptr;
    logic [c_AW-1:0]                 r_rptr;
    logic [c_AW:0]                   r_count;
    logic                            w_wr;
    logic                            w_rd;

    assign w_rd = pop && (r_count != '0);
    // A pop on the same edge frees the slot, so a push while full is still taken.
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= wdata;
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rssb_trace.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rssb_trace                                                           |
// | Captures rssb debug outputs on PC change and streams 5-word records. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rssb_trace
    import rssb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] opc,
    input  logic [WIDTH-1:0] omem,
    input  logic [WIDTH-1:0] oop1,
    input  logic [WIDTH-1:0] osub,
    input  logic [WIDTH-1:0] oacc,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             full,
    output logic             empty,
    output logic [7:0]       drop_cnt
);

    typedef logic [REC_WORDS-1:0][WIDTH-1:0] rec_t;

    localparam logic [0:0] c_ST_IDLE = IDLE;
    localparam logic [0:0] c_ST_SEND = SEND;

    logic [WIDTH-1:0] r_prev_pc;
    logic             r_armed;
    logic [7:0]       r_drop_cnt;
    logic [0:0]       r_state;
    rec_idx_t         r_idx;
    rec_t             r_hold;
    rec_t             w_capture;
    rec_t             w_fifo_rdata;
    logic             w_push_req;
    logic             w_pop;
    logic             w_hs;

    assign w_push_req = en && (!r_armed || (opc != r_prev_pc));
    assign w_capture  = {oacc, osub, oop1, omem, opc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_pc <= '0;
            r_armed   <= 1'b0;
        end else if (en) begin
            r_prev_pc <= opc;
            r_armed   <= 1'b1;
        end else begin
            r_armed   <= 1'b0;
        end
    end

    assign w_hs  = (r_state == c_ST_SEND) && tx_ready;
    // Pop when idle, or on the last word's handshake to chain records without a bubble.
    assign w_pop = !empty && ((r_state == c_ST_IDLE) || (w_hs && (r_idx == LAST_IDX)));

    rssb_trace_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .pop   (w_pop),
        .wdata (w_capture),
        .rdata (w_fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (w_push_req && full && !w_pop && (r_drop_cnt != 8'hff)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_hold  <= w_fifo_rdata;
                        r_idx   <= '0;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (w_hs) begin
                        if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 1'b1;
                        end else if (w_pop) begin
                            r_hold <= w_fifo_rdata;
                            r_idx  <= '0;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign tx_valid = (r_state == c_ST_SEND);
    assign tx_data  = tx_valid ? r_hold[r_idx] : '0;
    assign tx_last  = tx_valid && (r_idx == LAST_IDX);
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rssb_trace.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rssb_trace                                                        |
// | Directed bench for rssb_trace with hand-computed record streams.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_rssb_trace;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] opc = '0, omem = '0, oop1 = '0, osub = '0, oacc = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_last;
    logic       full, empty;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    rssb_trace #(.WIDTH(8), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .opc      (opc),
        .omem     (omem),
        .oop1     (oop1),
        .osub     (osub),
        .oacc     (oacc),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .full     (full),
        .empty    (empty),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a word on the port right now, then let the handshake happen.
    task automatic word(input string tag, input logic [7:0] exp, input logic last);
        chk({tag, "_valid"}, tx_valid, 1'b1);
        chk({tag, "_data"},  tx_data,  exp);
        chk({tag, "_last"},  tx_last,  last);
        tick();
    endtask

    task automatic rec(input string tag, input logic [7:0] pc, input logic [7:0] mem);
        word(tag, pc,      1'b0);
        word(tag, mem,     1'b0);
        word(tag, 8'd2,    1'b0);
        word(tag, 8'd253,  1'b0);
        word(tag, 8'd7,    1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // reset values
        #3;
        chk("rst_data",  tx_data,  8'd0);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_last",  tx_last,  1'b0);
        chk("rst_full",  full,     1'b0);
        chk("rst_empty", empty,    1'b1);
        chk("rst_drop",  drop_cnt, 8'd0);
        tick();
        rst = 1'b1;
        tick();

        // single record plus latency: push at E, pop at E+1
        en = 1'b1; tx_ready = 1'b1;
        opc = 8'd0; omem = 8'd5; oop1 = 8'd2; osub = 8'd253; oacc = 8'd7;
        tick();
        chk("lat_empty", empty,    1'b0);
        chk("lat_valid", tx_valid, 1'b0);
        opc = 8'd3;
        tick();
        rec("rec0", 8'd0, 8'd5);
        rec("rec3", 8'd3, 8'd5);
        chk("single_idle",  tx_valid, 1'b0);
        chk("single_empty", empty,    1'b1);

        // backpressure mid-record
        opc = 8'd9; omem = 8'd11;
        tick();
        tick();
        word("bp", 8'd9, 1'b0);
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_valid", tx_valid, 1'b1);
            chk("bp_hold_data",  tx_data,  8'd11);
        end
        tx_ready = 1'b1;
        word("bp", 8'd11,  1'b0);
        word("bp", 8'd2,   1'b0);
        word("bp", 8'd253, 1'b0);
        word("bp", 8'd7,   1'b1);
        chk("bp_idle", tx_valid, 1'b0);

        // enable gating
        omem = 8'd5;
        en = 1'b0;
        opc = 8'd20; tick();
        opc = 8'd21; tick();
        opc = 8'd22; tick();
        chk("gate_empty", empty,    1'b1);
        chk("gate_valid", tx_valid, 1'b0);
        en = 1'b1;
        tick();
        chk("gate_push", empty, 1'b0);
        tick();
        rec("gate", 8'd22, 8'd5);
        chk("gate_once_valid", tx_valid, 1'b0);
        chk("gate_once_empty", empty,    1'b1);

        // overflow: one record parked in the holding register, then 11 captures
        tx_ready = 1'b0;
        opc = 8'd30;
        tick();
        tick();
        chk("ovf_head", tx_data, 8'd30);
        for (int i = 0; i < 11; i++) begin
            opc = 8'(40 + i);
            tick();
        end
        chk("ovf_full",  full,     1'b1);
        chk("ovf_drop",  drop_cnt, 8'd3);
        chk("ovf_stall", tx_data,  8'd30);

        // release; new capture lands on the pop edge at the end of record 30
        tx_ready = 1'b1;
        word("r30", 8'd30,  1'b0);
        word("r30", 8'd5,   1'b0);
        word("r30", 8'd2,   1'b0);
        word("r30", 8'd253, 1'b0);
        chk("pp_last_data", tx_data, 8'd7);
        chk("pp_last_flag", tx_last, 1'b1);
        opc = 8'd60;
        tick();
        chk("pp_drop", drop_cnt, 8'd3);
        chk("pp_full", full,     1'b1);
        for (int k = 0; k < 8; k++) begin
            rec("ovf_rec", 8'(40 + k), 8'd5);
        end
        rec("pp_rec", 8'd60, 8'd5);
        chk("ovf_done_valid", tx_valid, 1'b0);
        chk("ovf_done_empty", empty,    1'b1);

        // reset during word 2
        opc = 8'd70;
        tick();
        tick();
        word("pre_rst", 8'd70, 1'b0);
        word("pre_rst", 8'd5,  1'b0);
        chk("pre_rst_w2", tx_data, 8'd2);
        rst = 1'b0;
        opc = 8'd80;
        #1;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_empty", empty,    1'b1);
        chk("mid_rst_drop",  drop_cnt, 8'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("post_rst_push", empty, 1'b0);
        tick();
        rec("post_rst", 8'd80, 8'd5);
        chk("post_rst_idle", tx_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rssb_trace.md
# rssb_trace

Downstream trace stage for the `rssb` one-instruction core. It samples the core's debug outputs (`opc`, `omem`, `oop1`, `osub`, `oacc`) each time the program counter changes and packs them into a 5-word record. Records are buffered in a small FIFO and streamed out one word per handshake over a valid/ready port, so a host, UART bridge or bench monitor can log execution without stalling the core.

## Interface
- `WIDTH`, default 8: data width; must match the core's `WIDTH`.
- `DEPTH`, default 8: FIFO depth in records; power of two, at least 2.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; every register clears immediately while low.
- `en`  in  1  capture enable.
- `opc`, `omem`, `oop1`, `osub`, `oacc`  in  WIDTH each  core debug outputs.
- `tx_data`  out  WIDTH  current record word.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the word.
- `tx_last`  out  1  high with the final word (`oacc`) of a record.
- `full`  out  1  FIFO holds DEPTH records.
- `empty`  out  1  FIFO holds 0 records.
- `drop_cnt`  out  8  count of discarded records; saturates at 255.

## Operation
- **Capture.** Registers `prev_pc` (reset 0) and `armed` (reset 0).
  - A push request occurs on an edge where `en` is high and either `armed`=0 or `opc` != `prev_pc`.
  - On every edge with `en` high: `prev_pc` <= `opc` and `armed` <= 1.
  - When `en` is low: `armed` <= 0 and no push occurs.
- **Record.** Word order is fixed: index 0 = `opc`, 1 = `omem`, 2 = `oop1`, 3 = `osub`, 4 = `oacc`.
  - All five values are sampled on the same edge.
- **FIFO.** Circular buffer with read/write pointers and a count of width clog2(DEPTH)+1.
  - A push while full with no simultaneous pop is discarded, and `drop_cnt` increments (saturating).
  - A push while full with a simultaneous pop is accepted.
  - A pop while empty never occurs.
- **Serializer.** FSM with states IDLE and SEND, a 5-word holding register, and a 3-bit index.
  - **IDLE:** `tx_valid`=0. If the FIFO is not empty: pop into the holding register, set index 0, and go to SEND.
  - **SEND:** `tx_valid`=1, `tx_data` = word[index], `tx_last` = (index==4).
    - On `tx_valid` && `tx_ready` with index<4: index increments.
    - On the handshake at index 4: if the FIFO is not empty, pop, set index 0 and stay in SEND (back-to-back records, no bubble); otherwise go to IDLE.
  - `tx_data` and index hold while `tx_ready` is low. A word is never dropped or repeated.
- **Reset values:** `tx_data`=0, `tx_valid`=0, `tx_last`=0, `full`=0, `empty`=1, `drop_cnt`=0, state IDLE.
- **Reset mid-record:** the partially sent record and all buffered records are lost. `tx_valid` falls asynchronously.

## Timing
- Let edge E be the first edge at which a new `opc` value is sampled (with `en`=1), with the FIFO empty and the FSM in IDLE.
  - The record is written at E.
  - It is popped at E+1.
  - `tx_valid` is high with word 0 after E+1, i.e. in the cycle following E+1.
- With `tx_ready` held high, a record occupies exactly 5 cycles on the output. Consecutive buffered records stream with no gap.
- `full`, `empty` and `drop_cnt` are registered and reflect the state after the latest edge.
- `tx_valid` does not depend combinationally on `tx_ready`.

## Structure
- Package `rssb_pkg` holds:
  - `REC_WORDS` = 5 and `rec_idx_t` (3-bit).
  - Enum `trace_state_t` {IDLE, SEND}.
  - A record typedef built as an array of `REC_WORDS` words of `WIDTH` bits.
- Sub-module `rssb_trace_fifo`: parameterised synchronous FIFO with push/pop/full/empty and a record-wide data port.
- Capture logic, drop counter and serializer FSM live in `rssb_trace`.

## Test plan
- **Single record:** hold `en`=1 and `tx_ready`=1; drive `opc` 0→3 with `omem`=5, `oop1`=2, `osub`=253, `oacc`=7.
  - Output is the record for `opc`=0, then 3,5,2,253,7.
  - `tx_last` is high only on the word 7.
- **Backpressure:** hold `tx_ready`=0 for 4 cycles mid-record.
  - `tx_data` is stable throughout.
  - Remaining words arrive in order once `tx_ready` returns high; no duplicates.
- **Overflow:** hold `tx_ready`=0 and produce 11 distinct `opc` values with DEPTH=8.
  - `full`=1 and `drop_cnt`=3.
  - After release, exactly 8 records stream out in capture order.
- **Full with simultaneous push and pop:** with the FIFO full and a pop occurring, a new `opc` change arrives.
  - The push is accepted and `drop_cnt` is unchanged.
- **Enable gating:** with `en`=0, change `opc` several times → no records.
  - Raising `en` with `opc` unchanged emits exactly one record.
- **Reset mid-record:** assert `rst` low during word 2.
  - `tx_valid`=0, `empty`=1 and `drop_cnt`=0 immediately.
  - After release, the first record emitted is the fresh capture.
